// File: rtl/rect_motion_ctl.sv
// Per-frame position controller for one rectangular sprite: button-driven motion,
// edge clamping and a post-collision freeze. Define RECT_MOTION_WRAP_EN to wrap at edges.
module rect_motion_ctl #(
    parameter int SCREEN_W   = 1024,
    parameter int SCREEN_H   = 768,
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int STEP       = 4,
    parameter int X_INIT     = 480,
    parameter int Y_INIT     = 352,
    parameter int HIT_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vblnk_in,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        collision_in,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        collision_out,
    output logic [1:0]  state_out,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_HIT   = 2'd2;
    localparam logic [12:0] X_MAX    = 13'(SCREEN_W - WIDTH);
    localparam logic [12:0] Y_MAX    = 13'(SCREEN_H - HEIGHT);
    localparam logic [12:0] STEP13   = 13'(STEP);
    localparam logic [7:0]  HIT_LOAD = 8'(HIT_FRAMES);

    logic [1:0]  state_reg, state_next;
    logic [11:0] x_reg, x_next;
    logic [11:0] y_reg, y_next;
    logic        col_reg, col_next;
    logic [15:0] fc_reg, fc_next;
    logic [7:0]  hit_cnt_reg, hit_cnt_next;
    logic        sticky_reg, sticky_next;
    logic        vblnk_prev_reg;
    logic        tick;
    logic        hit_evt;

    // One axis step; 13-bit arithmetic keeps pos+STEP from overflowing.
    function automatic logic [11:0] axis_next(input logic [11:0] pos, input logic inc,
                                              input logic dec, input logic [12:0] lim);
        logic [12:0] p;
        logic [12:0] up;
        logic [12:0] res;
        p   = {1'b0, pos};
        up  = p + STEP13;
        res = p;
`ifdef RECT_MOTION_WRAP_EN
        if (inc && !dec)
            res = (up > lim) ? 13'd0 : up;
        else if (dec && !inc)
            res = (p < STEP13) ? lim : p - STEP13;
`else
        if (inc && !dec)
            res = (up > lim) ? lim : up;
        else if (dec && !inc)
            res = (p < STEP13) ? 13'd0 : p - STEP13;
        // Also pulls an out-of-range start position back inside on the first move.
        if (res > lim)
            res = lim;
`endif
        return res[11:0];
    endfunction

    assign tick    = vblnk_in & ~vblnk_prev_reg;
    assign hit_evt = collision_in | sticky_reg;

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        col_next     = col_reg;
        fc_next      = fc_reg;
        hit_cnt_next = hit_cnt_reg;
        sticky_next  = tick ? 1'b0 : (sticky_reg | collision_in);
        if (!enable) begin
            state_next   = ST_IDLE;
            col_next     = 1'b0;
            sticky_next  = 1'b0;
            hit_cnt_next = 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_RUN;
                ST_RUN: begin
                    if (tick) begin
                        fc_next = fc_reg + 16'd1;
                        if (hit_evt) begin
                            state_next   = ST_HIT;
                            hit_cnt_next = HIT_LOAD;
                            col_next     = 1'b1;
                        end else begin
                            x_next = axis_next(x_reg, btn_right, btn_left, X_MAX);
                            y_next = axis_next(y_reg, btn_down, btn_up, Y_MAX);
                        end
                    end
                end
                ST_HIT: begin
                    if (tick) begin
                        fc_next = fc_reg + 16'd1;
                        if (hit_evt) begin
                            hit_cnt_next = HIT_LOAD;
                        end else if (hit_cnt_reg <= 8'd1) begin
                            state_next   = ST_RUN;
                            hit_cnt_next = 8'd0;
                            col_next     = 1'b0;
                        end else begin
                            hit_cnt_next = hit_cnt_reg - 8'd1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            x_reg          <= 12'(X_INIT);
            y_reg          <= 12'(Y_INIT);
            col_reg        <= 1'b0;
            fc_reg         <= 16'd0;
            hit_cnt_reg    <= 8'd0;
            sticky_reg     <= 1'b0;
            vblnk_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            col_reg        <= col_next;
            fc_reg         <= fc_next;
            hit_cnt_reg    <= hit_cnt_next;
            sticky_reg     <= sticky_next;
            vblnk_prev_reg <= vblnk_in;
        end
    end

    assign x_pos         = x_reg;
    assign y_pos         = y_reg;
    assign collision_out = col_reg;
    assign state_out     = state_reg;
    assign frame_cnt     = fc_reg;

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Directed bench for rect_motion_ctl: motion, clamping, collision freeze and async reset.
// A second instance with X_INIT=958 covers the right-edge limit.
module tb_rect_motion_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic        collision_in = 1'b0;
    logic [11:0] x_pos, y_pos;
    logic        collision_out;
    logic [1:0]  state_out;
    logic [15:0] frame_cnt;

    logic        enable_e = 1'b0, btn_right_e = 1'b0;
    logic [11:0] x_pos_e, y_pos_e;
    logic        collision_out_e;
    logic [1:0]  state_out_e;
    logic [15:0] frame_cnt_e;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rect_motion_ctl dut (
        .clk(clk), .rst(rst), .enable(enable), .vblnk_in(vblnk_in),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .collision_in(collision_in), .x_pos(x_pos), .y_pos(y_pos),
        .collision_out(collision_out), .state_out(state_out), .frame_cnt(frame_cnt)
    );

    rect_motion_ctl #(.X_INIT(958)) dut_edge (
        .clk(clk), .rst(rst), .enable(enable_e), .vblnk_in(vblnk_in),
        .btn_left(1'b0), .btn_right(btn_right_e), .btn_up(1'b0), .btn_down(1'b0),
        .collision_in(1'b0), .x_pos(x_pos_e), .y_pos(y_pos_e),
        .collision_out(collision_out_e), .state_out(state_out_e), .frame_cnt(frame_cnt_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One frame: vblnk high for 2 cycles then low for 3; returns just after a negedge.
    task automatic frame();
        @(negedge clk) vblnk_in = 1'b1;
        repeat (2) @(negedge clk);
        vblnk_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_collision();
        @(negedge clk) collision_in = 1'b1;
        @(negedge clk) collision_in = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_x", 32'(x_pos), 32'd480);
        chk("rst_y", 32'(y_pos), 32'd352);
        chk("rst_col", 32'(collision_out), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_fc", 32'(frame_cnt), 32'd0);
        rst = 1'b0;

        // IDLE ignores ticks
        btn_right = 1'b1;
        frame();
        frame();
        chk("idle_x", 32'(x_pos), 32'd480);
        chk("idle_fc", 32'(frame_cnt), 32'd0);
        chk("idle_state", 32'(state_out), 32'd0);

        enable = 1'b1;
        enable_e = 1'b1;
        btn_right_e = 1'b1;
        @(negedge clk);
        chk("run_state", 32'(state_out), 32'd1);
        frame();
        chk("right1_x", 32'(x_pos), 32'd484);
`ifdef RECT_MOTION_WRAP_EN
        chk("edge1_x", 32'(x_pos_e), 32'd0);
`else
        chk("edge1_x", 32'(x_pos_e), 32'd960);
`endif
        frame();
        chk("right2_x", 32'(x_pos), 32'd488);
`ifdef RECT_MOTION_WRAP_EN
        chk("edge2_x", 32'(x_pos_e), 32'd4);
`else
        chk("edge2_x", 32'(x_pos_e), 32'd960);
`endif
        enable_e = 1'b0;
        frame();
        chk("right3_x", 32'(x_pos), 32'd492);
        chk("right3_y", 32'(y_pos), 32'd352);
        chk("right3_fc", 32'(frame_cnt), 32'd3);
        chk("right3_state", 32'(state_out), 32'd1);

        // Opposing buttons cancel
        btn_left = 1'b1;
        for (int i = 0; i < 4; i++) frame();
        chk("lr_x", 32'(x_pos), 32'd492);
        chk("lr_fc", 32'(frame_cnt), 32'd7);
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 4; i++) frame();
        chk("ud_y", 32'(y_pos), 32'd352);
        chk("ud_fc", 32'(frame_cnt), 32'd11);
        btn_up = 1'b0;
        btn_down = 1'b0;

        // Mid-frame collision pulse: freeze for 8 ticks
        btn_right = 1'b1;
        pulse_collision();
        frame();
        chk("hit_state", 32'(state_out), 32'd2);
        chk("hit_col", 32'(collision_out), 32'd1);
        chk("hit_x", 32'(x_pos), 32'd492);
        chk("hit_fc", 32'(frame_cnt), 32'd12);
        for (int i = 0; i < 7; i++) frame();
        chk("hit7_state", 32'(state_out), 32'd2);
        chk("hit7_x", 32'(x_pos), 32'd492);
        frame();
        chk("hit8_state", 32'(state_out), 32'd1);
        chk("hit8_col", 32'(collision_out), 32'd0);
        chk("hit8_x", 32'(x_pos), 32'd492);
        frame();
        chk("resume_x", 32'(x_pos), 32'd496);
        chk("resume_fc", 32'(frame_cnt), 32'd21);

        // Re-collision during HIT reloads the counter
        pulse_collision();
        frame();
        chk("rehit_state", 32'(state_out), 32'd2);
        for (int i = 0; i < 5; i++) frame();
        pulse_collision();
        frame();
        chk("reload_state", 32'(state_out), 32'd2);
        for (int i = 0; i < 7; i++) frame();
        chk("reload7_col", 32'(collision_out), 32'd1);
        frame();
        chk("reload8_col", 32'(collision_out), 32'd0);
        chk("reload8_state", 32'(state_out), 32'd1);
        chk("reload8_x", 32'(x_pos), 32'd496);
        chk("reload8_fc", 32'(frame_cnt), 32'd36);

        // Asynchronous reset while in HIT
        pulse_collision();
        frame();
        frame();
        chk("prerst_state", 32'(state_out), 32'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_x", 32'(x_pos), 32'd480);
        chk("arst_y", 32'(y_pos), 32'd352);
        chk("arst_col", 32'(collision_out), 32'd0);
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_fc", 32'(frame_cnt), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Diagonal to the bottom-left corner
        btn_right = 1'b0;
        btn_left = 1'b1;
        btn_down = 1'b1;
        frame();
        chk("diag1_x", 32'(x_pos), 32'd476);
        chk("diag1_y", 32'(y_pos), 32'd356);
        for (int i = 0; i < 129; i++) frame();
        chk("corner_x", 32'(x_pos), 32'd0);
        chk("corner_y", 32'(y_pos), 32'd704);
        btn_left = 1'b0;
        btn_down = 1'b0;

        // enable=0 during HIT drops to IDLE and clears the pending hit
        pulse_collision();
        frame();
        chk("dis_pre_state", 32'(state_out), 32'd2);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_state", 32'(state_out), 32'd0);
        chk("dis_col", 32'(collision_out), 32'd0);
        chk("dis_y", 32'(y_pos), 32'd704);
        enable = 1'b1;
        @(negedge clk);
        frame();
        chk("reen_state", 32'(state_out), 32'd1);
        chk("reen_col", 32'(collision_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
